// File: rtl/bus_cmp_pkg.sv
// bus_cmp_pkg: shared state encoding, outSel/outputStatus encodings and default limits
package bus_cmp_pkg;
  typedef enum logic [1:0] {IDLE, DECIDE, SEND, DONE} state_t;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam int STAT_BUSY = 1;
  localparam int STAT_ERR = 0;
  localparam int DEF_FAULT_LIMIT = 3;
  localparam int DEF_RECOVER_LIMIT = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/ch_health.sv
// ch_health: per-channel consecutive-fault counter with failed flag and recovery counter
//   upd strobes one frame verdict (good); fault_cnt/fail are the registered health outputs
module ch_health #(
  parameter int FAULT_LIMIT = 3,
  parameter int RECOVER_LIMIT = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic             good,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             fail
);
  logic [CNT_W-1:0] fault_q, fault_d, good_q, good_d;
  logic fail_q, fail_d;
  always_comb begin
    fault_d = fault_q;
    good_d = good_q;
    fail_d = fail_q;
    if (upd && !good) begin
      fault_d = &fault_q ? fault_q : fault_q + 1'b1;
      good_d = '0;
      fail_d = fail_q | (fault_d >= CNT_W'(FAULT_LIMIT));
    end else if (upd && fail_q) begin
      fault_d = '0;
      good_d = good_q + 1'b1;
      fail_d = good_d != CNT_W'(RECOVER_LIMIT);
      good_d = fail_d ? good_d : '0;
    end else if (upd) begin
      fault_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= '0;
      good_q <= '0;
      fail_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
      good_q <= good_d;
      fail_q <= fail_d;
    end
  end
  assign fault_cnt = fault_q;
  assign fail = fail_q;
endmodule

// File: rtl/out_arbiter.sv
// out_arbiter: picks a redundant channel per frame and drives it downstream with valid/ready
//   outputEn (active-low) requests a frame; outValid/outData/outReady handshake the word;
//   outSel names the chosen channel; outputStatus = {busy, error}; chFail/faultCnt* report health
module out_arbiter
  import bus_cmp_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FAULT_LIMIT = DEF_FAULT_LIMIT,
  parameter int RECOVER_LIMIT = DEF_RECOVER_LIMIT,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              outputEn,
  input  logic              crcOk1,
  input  logic              crcOk2,
  input  logic              compMatch,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              outReady,
  output logic              outValid,
  output logic [DATA_W-1:0] outData,
  output logic [1:0]        outSel,
  output logic [1:0]        outputStatus,
  output logic [1:0]        chFail,
  output logic [CNT_W-1:0]  faultCnt1,
  output logic [CNT_W-1:0]  faultCnt2
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic crc1_q, crc1_d, crc2_q, crc2_d, match_q, match_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, data_q, data_d;
  logic valid_q, valid_d;
  logic [1:0] sel_q, sel_d, stat_q, stat_d;
  logic [TW-1:0] to_q, to_d, to_nx;
  logic mism, good1, good2, elig1, elig2, upd;
  always_comb begin
    mism = crc1_q & crc2_q & ~match_q;
    good1 = crc1_q & ~mism;
    good2 = crc2_q & ~mism;
    // eligibility uses the pre-update flag, so a channel recovering this frame still sits out
    elig1 = good1 & ~chFail[0];
    elig2 = good2 & ~chFail[1];
    upd = state_q == DECIDE;
    to_nx = to_q + 1'b1;
    state_d = state_q;
    crc1_d = crc1_q;
    crc2_d = crc2_q;
    match_d = match_q;
    d1_d = d1_q;
    d2_d = d2_q;
    data_d = data_q;
    valid_d = valid_q;
    sel_d = sel_q;
    stat_d = stat_q;
    to_d = to_q;
    case (state_q)
      IDLE: begin
        stat_d = '0;
        if (!outputEn) begin
          crc1_d = crcOk1;
          crc2_d = crcOk2;
          match_d = compMatch;
          d1_d = data1;
          d2_d = data2;
          stat_d[STAT_BUSY] = 1'b1;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        sel_d = elig1 ? SEL_CH1 : elig2 ? SEL_CH2 : SEL_NONE;
        data_d = elig1 ? d1_q : elig2 ? d2_q : data_q;
        stat_d[STAT_BUSY] = elig1 | elig2;
        stat_d[STAT_ERR] = ~(elig1 | elig2);
        state_d = (elig1 | elig2) ? SEND : DONE;
      end
      SEND: begin
        // first SEND cycle raises outValid, giving the two-cycle request-to-valid latency
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (outReady) begin
          valid_d = 1'b0;
          stat_d = '0;
          state_d = DONE;
        end else if (to_nx == TW'(TIMEOUT)) begin
          valid_d = 1'b0;
          stat_d = '0;
          stat_d[STAT_ERR] = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_nx;
        end
      end
      DONE: begin
        if (outputEn) begin
          stat_d = '0;
          to_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      crc1_q <= 1'b0;
      crc2_q <= 1'b0;
      match_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      sel_q <= SEL_NONE;
      stat_q <= '0;
      to_q <= '0;
    end else begin
      state_q <= state_d;
      crc1_q <= crc1_d;
      crc2_q <= crc2_d;
      match_q <= match_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      data_q <= data_d;
      valid_q <= valid_d;
      sel_q <= sel_d;
      stat_q <= stat_d;
      to_q <= to_d;
    end
  end
  ch_health #(.FAULT_LIMIT(FAULT_LIMIT), .RECOVER_LIMIT(RECOVER_LIMIT), .CNT_W(CNT_W)) u_h1 (
    .clk(clk), .rst(rst), .upd(upd), .good(good1), .fault_cnt(faultCnt1), .fail(chFail[0])
  );
  ch_health #(.FAULT_LIMIT(FAULT_LIMIT), .RECOVER_LIMIT(RECOVER_LIMIT), .CNT_W(CNT_W)) u_h2 (
    .clk(clk), .rst(rst), .upd(upd), .good(good2), .fault_cnt(faultCnt2), .fail(chFail[1])
  );
  assign outValid = valid_q;
  assign outData = data_q;
  assign outSel = sel_q;
  assign outputStatus = stat_q;
endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: random and directed frames checked against a frame-level reference model
module tb_out_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic outputEn = 1'b1;
  logic crcOk1 = 1'b0, crcOk2 = 1'b0, compMatch = 1'b0;
  logic [63:0] data1 = '0, data2 = '0;
  logic outReady = 1'b0;
  logic outValid;
  logic [63:0] outData;
  logic [1:0] outSel, outputStatus, chFail;
  logic [3:0] faultCnt1, faultCnt2;
  int n_vec = 0, n_err = 0;
  int fcnt[2], gcnt[2];
  bit fail[2];

  out_arbiter dut (
    .clk(clk), .rst(rst), .outputEn(outputEn), .crcOk1(crcOk1), .crcOk2(crcOk2),
    .compMatch(compMatch), .data1(data1), .data2(data2), .outReady(outReady),
    .outValid(outValid), .outData(outData), .outSel(outSel), .outputStatus(outputStatus),
    .chFail(chFail), .faultCnt1(faultCnt1), .faultCnt2(faultCnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      fcnt[i] = 0;
      gcnt[i] = 0;
      fail[i] = 0;
    end
  endfunction

  function automatic void model_health(input int i, input bit g);
    if (!g) begin
      fcnt[i] = fcnt[i] < 15 ? fcnt[i] + 1 : 15;
      gcnt[i] = 0;
      if (fcnt[i] >= 3) fail[i] = 1;
    end else begin
      fcnt[i] = 0;
      if (fail[i]) begin
        gcnt[i]++;
        if (gcnt[i] == 8) begin
          fail[i] = 0;
          gcnt[i] = 0;
        end
      end
    end
  endfunction

  // delay: valid cycles before outReady rises; negative or >254 means the word times out
  task automatic run_frame(input bit c1, input bit c2, input bit m, input int delay);
    logic [63:0] d1, d2, ed;
    bit mis, g1, g2, e1, e2, eerr;
    int es, k;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    mis = c1 && c2 && !m;
    g1 = c1 && !mis;
    g2 = c2 && !mis;
    e1 = g1 && !fail[0];
    e2 = g2 && !fail[1];
    es = e1 ? 1 : e2 ? 2 : 0;
    ed = e1 ? d1 : d2;
    model_health(0, g1);
    model_health(1, g2);
    @(negedge clk);
    outputEn = 1'b0;
    crcOk1 = c1;
    crcOk2 = c2;
    compMatch = m;
    data1 = d1;
    data2 = d2;
    @(posedge clk);
    #1;
    crcOk1 = 1'($urandom);
    crcOk2 = 1'($urandom);
    compMatch = 1'($urandom);
    data1 = {$urandom, $urandom};
    data2 = {$urandom, $urandom};
    check("busy", outputStatus, 2'b10);
    check("lat1", outValid, 0);
    @(posedge clk);
    #1;
    check("sel", outSel, es);
    check("fcnt1", faultCnt1, fcnt[0]);
    check("fcnt2", faultCnt2, fcnt[1]);
    check("chfail", chFail, {fail[1], fail[0]});
    check("lat2", outValid, 0);
    eerr = 1;
    if (es != 0) begin
      @(posedge clk);
      #1;
      check("valid", outValid, 1);
      check("data", outData, ed);
      check("busy2", outputStatus, 2'b10);
      k = 0;
      while (outValid && k < 300) begin
        outReady = (k == delay);
        @(posedge clk);
        #1;
        if (outValid) check("hold", outData, ed);
        k++;
      end
      outReady = 1'b0;
      eerr = !(delay >= 0 && delay <= 254);
      check("vlen", k, eerr ? 255 : delay + 1);
    end
    check("stat", outputStatus, {1'b0, eerr});
    @(posedge clk);
    #1;
    check("done_hold", outputStatus, {1'b0, eerr});
    check("no_new", outValid, 0);
    outputEn = 1'b1;
    @(posedge clk);
    #1;
    check("idle", outputStatus, 0);
  endtask

  initial begin
    model_reset();
    #3 rst = 1'b0;
    #2;
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 0);
    check("rst_sel", outSel, 0);
    check("rst_stat", outputStatus, 0);
    check("rst_fail", chFail, 0);
    check("rst_fc", {faultCnt2, faultCnt1}, 0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) run_frame(0, 1, 1, 0);
    run_frame(1, 1, 0, 0);
    for (int i = 0; i < 9; i++) run_frame(1, 1, 1, i % 3);
    run_frame(1, 1, 1, -1);
    run_frame(1, 1, 1, 254);
    run_frame(1, 1, 1, 253);
    for (int i = 0; i < 3; i++) run_frame(0, 1, 1, 1);
    @(negedge clk);
    outputEn = 1'b0;
    crcOk1 = 1'b1;
    crcOk2 = 1'b1;
    compMatch = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", outValid, 1);
    check("pre_rst_fail", chFail, 2'b01);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", outValid, 0);
    check("mid_rst_fail", chFail, 0);
    check("mid_rst_fc", {faultCnt2, faultCnt1}, 0);
    check("mid_rst_stat", outputStatus, 0);
    model_reset();
    @(negedge clk);
    outputEn = 1'b1;
    rst = 1'b1;
    run_frame(1, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      int dl;
      dl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      run_frame($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, dl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
